// File: rtl/apb_requester_if.sv
// Command, response and APB requester-side signal bundle for apb_requester.
interface apb_requester_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  timeout_pulse;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    input  rsp_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, timeout_pulse,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    output rsp_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, timeout_pulse,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_requester.sv
// APB5 requester: one outstanding transfer from a valid/ready command stream,
// completer response returned through a one-entry valid/ready buffer.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic             PCLK,
  input logic             PRESETn,
  apb_requester_if.master bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q,      state_d;
  logic                  psel_q,       psel_d;
  logic                  penable_q,    penable_d;
  logic                  pwrite_q,     pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,      pstrb_d;
  logic [2:0]            pprot_q,      pprot_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;
  logic                  timeout_q,    timeout_d;
  logic                  cmd_ready_c;
  logic                  cmd_accept_c;

  // Gated by reset so that every output reads 0 while PRESETn is low
  assign cmd_ready_c  = PRESETn && (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);
  assign cmd_accept_c = bus.cmd_valid && cmd_ready_c;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;

    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_accept_c) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          pprot_d  = bus.cmd_prot;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d  = pwrite_q ? '0 : bus.PRDATA;
          rsp_slverr_d = bus.PSLVERR;
          rsp_valid_d  = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE;
        end else if (TIMEOUT_EN && (cnt_q != CNT_MAX)) begin
          // Saturates at the threshold, so the pulse fires once per transfer
          cnt_d     = cnt_q + CNT_WIDTH'(1);
          timeout_d = (cnt_d == CNT_MAX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pprot_q      <= pprot_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.PSEL          = psel_q;
  assign bus.PENABLE       = penable_q;
  assign bus.PWRITE        = pwrite_q;
  assign bus.PADDR         = paddr_q;
  assign bus.PWDATA        = pwdata_q;
  assign bus.PSTRB         = pstrb_q;
  assign bus.PPROT         = pprot_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_slverr    = rsp_slverr_q;
  assign bus.timeout_pulse = timeout_q;
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB5 requester that converts a valid/ready command stream into APB transfers.
- Returns each completer response on a valid/ready response stream.
- Sits directly upstream of the APB bus and drives every requester-side signal that the APB protocol checker monitors.
- Holds at most one outstanding transfer; the response is buffered in a one-entry register.

Parameters:
- ADDR_WIDTH, 32, PADDR/cmd_addr width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8; PSTRB width = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, access-phase wait-cycle count at which timeout_pulse fires; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  PRDATA captured (0 for writes)
- rsp_slverr  out  1  PSLVERR captured
- timeout_pulse  out  1  one-cycle pulse when wait count reaches TIMEOUT_CYCLES
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH
- PWDATA  out  DATA_WIDTH
- PSTRB  out  DATA_WIDTH/8
- PPROT  out  3
- PREADY  in  1
- PRDATA  in  DATA_WIDTH
- PSLVERR  in  1

Behaviour:
- Reset (asynchronous, PRESETn low): every output is 0, state=IDLE, wait counter=0. Asserting reset mid-transfer drops the transfer and any buffered response.
- States: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready). It is combinational and independent of cmd_valid.
- IDLE: on accept, register cmd_addr/cmd_write/cmd_wdata/cmd_prot onto PADDR/PWRITE/PWDATA/PPROT. PSTRB = cmd_write ? cmd_strb : 0, so reads always drive PSTRB=0. Set PSEL=1, PENABLE=0, go to SETUP. Without accept, PSEL=0, PENABLE=0, and PADDR/PWRITE/PWDATA/PSTRB/PPROT hold their last values.
- SETUP: exactly one cycle; PENABLE<=1; go to ACCESS.
- ACCESS, PREADY=0: hold every APB output unchanged; wait counter +1, saturating.
- Timeout: timeout_pulse=1 for exactly the cycle after the counter reaches TIMEOUT_CYCLES; it does not re-fire. The transfer is never aborted, so PSEL stays high.
- ACCESS, PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_slverr = PSLVERR. Set rsp_valid<=1, PSEL<=0, PENABLE<=0, counter<=0, go to IDLE.
- Latency: accept at cycle N gives SETUP at N+1 and ACCESS at N+2. With zero wait states, rsp_valid rises at N+3.
- Back-to-back: minimum one IDLE cycle between transfers (PSEL low); full throughput is one transfer per 3 cycles.
- rsp_valid clears on rsp_ready. rsp_rdata/rsp_slverr are stable while rsp_valid && !rsp_ready.
- Simultaneous rsp_ready and a new accept in IDLE: the response is consumed and the new command is accepted in the same cycle.
- Outputs are protocol-clean: the protocol checker must report no assertion failures for any cmd/rsp stimulus.

Test Plan:
- Write, no wait: addr=0x40, wdata=0xDEADBEEF, strb=0xF, prot=3'b010 -> PSEL high 2 cycles, PENABLE in the 2nd, PSTRB=0xF; rsp_valid at accept+3, rsp_rdata=0, rsp_slverr=0.
- Read, 3 wait states: addr=0x100, cmd_strb=0xF; completer returns PRDATA=0x12345678 with PSLVERR=1 -> PSTRB=0 throughout; PADDR stable 5 cycles; rsp_rdata=0x12345678, rsp_slverr=1.
- Response backpressure: rsp_ready=0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, PSEL=0, response held. Raise rsp_ready -> new command accepted in the same cycle.
- Timeout: TIMEOUT_CYCLES=4, PREADY low 10 cycles -> timeout_pulse exactly once, on the 5th access cycle; transfer completes normally when PREADY rises.
- Reset mid-ACCESS: drop PRESETn during a wait state -> PSEL/PENABLE/rsp_valid go to 0 immediately (asynchronously); after release, a new read completes correctly.
- Stress: 200 random commands with random wait states and rsp_ready patterns -> responses match the model in order; zero checker assertion failures.
